pin_mux_sel_ctrl: RTL and testbench
===================================

# pin_mux_sel_ctrl

Sequencer that owns the per-pin function-select vector of the pin multiplexer and applies selection changes one pin at a time without glitching the pad. It accepts change requests over a valid/ready handshake. For each accepted change it forces the affected pad to input (oeb high) for a guard interval, switches the 2-bit select, holds the force for a settle interval, then releases the pad. It sits between the configuration register bank and the pin mux: `sel` drives the mux select directly, and `oeb_force` is ORed into the mux's `io_oeb` outputs.

## Interface
Parameters:
- `COUNT`, 16: number of pins; legal range 1..16.
- `GUARD`, 4: forced-input cycles before the select changes; ≥1.
- `SETTLE`, 2: forced-input cycles after the select changes; ≥1.
- `RESET_SEL`, 0: 2-bit reset function applied to every pin.

Ports:
- `clk`, input, 1: the single clock; all state changes on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `req_valid`, input, 1: a change request is present.
- `req_ready`, output, 1: high only in IDLE.
- `req_pin`, input, 4: target pin index.
- `req_sel`, input, 2: new function for the target pin.
- `lock`, input, COUNT: per-pin lock; a request to a locked pin is rejected.
- `sel`, output, COUNT*2: mux select; pin i uses bits [2i+1:2i].
- `oeb_force`, output, COUNT: 1 forces pad i to input.
- `busy`, output, 1: high when not in IDLE.
- `done`, output, 1: one-cycle pulse when a request completes, including a no-op.
- `err`, output, 1: one-cycle pulse when a request is rejected.

## Operation
Reset values:
- `sel` is RESET_SEL replicated to every pin.
- `oeb_force`, `done`, `err` and `busy` are 0.
- `req_ready` is 1; the state is IDLE.

FSM states are IDLE, GUARD, SWITCH and SETTLE. A down-counter is sized for max(GUARD,SETTLE).

IDLE: a handshake occurs when `req_valid` and `req_ready` are both high at a rising edge. The request is then handled by the first matching rule below:
- Reject: `req_pin ≥ COUNT` or `lock[req_pin]` is 1. `err` pulses on the next cycle, the state stays IDLE and nothing else changes.
- No-op: `req_sel` equals the current select of that pin. `done` pulses on the next cycle, the state stays IDLE and no force is applied.
- Change: the controller latches pin and sel, sets `oeb_force[pin]`, loads the counter with GUARD-1 and moves to GUARD.

GUARD: the counter decrements each cycle. When the counter reaches 0, the state moves to SWITCH.

SWITCH: one cycle. At its closing edge, the latched value is written into `sel[2p+1:2p]`, the counter is loaded with SETTLE-1 and the state moves to SETTLE.

SETTLE: the counter decrements each cycle. When it reaches 0:
- `oeb_force[pin]` is cleared,
- `done` pulses for one cycle,
- the state returns to IDLE.

Rules that apply in every state:
- Only one pin is in transition at a time; every other `sel` field and `oeb_force` bit holds.
- `lock` is sampled only at the handshake. A lock that changes during a sequence does not abort it.
- The latched pin and sel are used for the whole sequence. `req_*` inputs are ignored outside IDLE.
- Reset asserted mid-sequence immediately returns every output to its reset value, including `sel`, which reverts to RESET_SEL.

## Timing
Let E0 be the handshake edge of a change request.
- `req_ready` and `busy` change on the cycle after E0.
- `oeb_force[p]` is high from after E0 until after edge E0+GUARD+1+SETTLE, which is exactly GUARD+1+SETTLE cycles.
- `sel[p]` changes after edge E0+GUARD+1. This gives GUARD+1 forced cycles before the change and SETTLE forced cycles after it.
- `done` is high in the cycle after edge E0+GUARD+1+SETTLE. `req_ready` is also 1 in that cycle, so a new request can be accepted there (back-to-back).
- Reject and no-op requests complete after a single edge: `err` or `done` is high in the cycle after E0, and `req_ready` stays 1 throughout.
- Throughput for back-to-back changes is one change per GUARD+SETTLE+2 cycles.
- `done` and `err` are never high together.

## Test plan
- Defaults, `sel` pin 3 = 0, request pin 3 → sel 2: `oeb_force[3]` is high for 7 cycles, `sel[7:6]` becomes 2 on the 6th cycle after E0 (after edge E0+5), and `done` pulses on the cycle after edge E0+7. All other bits are unchanged throughout.
- Request pin 5 → sel 0 while pin 5 is already 0: `done` pulses in cycle E0+1, `oeb_force` stays 0 and `busy` never asserts.
- `lock[2]`=1, request pin 2 → sel 1: `err` pulses in cycle E0+1 and `sel` is unchanged. Repeating with COUNT=12 and pin 13 also gives `err` with no state change.
- Two back-to-back changes (pin 0 → 1, then pin 15 → 3) with `req_valid` held high: the second request is accepted in the `done` cycle of the first. The `oeb_force` bits for pins 0 and 15 never overlap, and both selects end at their new values.
- Assert `rst` in the 2nd GUARD cycle of a pin 4 → 3 change: immediately `oeb_force`=0, `sel` is all RESET_SEL, `busy`=0 and `req_ready`=1. After release, a new request runs the full sequence normally.
- With GUARD=1 and SETTLE=1, request pin 1 → 2: `oeb_force[1]` is high for 3 cycles, the select changes after edge E0+2, and `done` is high in the cycle after edge E0+3.

Source files
------------

// File: rtl/pin_mux_sel_ctrl.sv
// Pin-mux function-select sequencer: applies one select change at a time,
// forcing the pad to input around the switch so the pad never glitches.
module pin_mux_sel_ctrl #(
    parameter int         COUNT     = 16,
    parameter int         GUARD     = 4,
    parameter int         SETTLE    = 2,
    parameter logic [1:0] RESET_SEL = 2'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_pin,
    input  logic [1:0]           req_sel,
    input  logic [COUNT-1:0]     lock,
    output logic [COUNT*2-1:0]   sel,
    output logic [COUNT-1:0]     oeb_force,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int MAXC = (GUARD > SETTLE) ? GUARD : SETTLE;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GUARD  = 2'd1,
        ST_SWITCH = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t               state_r;
    logic [CW-1:0]        cnt_r;
    logic [3:0]           pin_r;
    logic [1:0]           sel_lat_r;
    logic [COUNT*2-1:0]   sel_r;
    logic [COUNT-1:0]     oeb_r;
    logic                 ready_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 err_r;

    logic                 pin_valid_s;
    logic                 lock_hit_s;
    logic [1:0]           cur_sel_s;

    // One-hot mask for a pin index; indices at or above COUNT give all zeros.
    function automatic logic [COUNT-1:0] pin_mask(input logic [3:0] p);
        logic [COUNT-1:0] m;
        m = '0;
        for (int i = 0; i < COUNT; i++) begin
            m[i] = (p == 4'(i));
        end
        return m;
    endfunction

    // Decode the requested pin: range check, lock bit and its current select.
    always_comb begin
        pin_valid_s = 1'b0;
        lock_hit_s  = 1'b0;
        cur_sel_s   = 2'd0;
        for (int i = 0; i < COUNT; i++) begin
            pin_valid_s = pin_valid_s | (req_pin == 4'(i));
            lock_hit_s  = (req_pin == 4'(i)) ? lock[i] : lock_hit_s;
            cur_sel_s   = (req_pin == 4'(i)) ? sel_r[2*i +: 2] : cur_sel_s;
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            pin_r     <= 4'd0;
            sel_lat_r <= 2'd0;
            sel_r     <= {COUNT{RESET_SEL}};
            oeb_r     <= '0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && ready_r) begin
                        if (!pin_valid_s || lock_hit_s) begin
                            err_r <= 1'b1;
                        end else if (cur_sel_s == req_sel) begin
                            done_r <= 1'b1;
                        end else begin
                            pin_r     <= req_pin;
                            sel_lat_r <= req_sel;
                            oeb_r     <= pin_mask(req_pin);
                            cnt_r     <= CW'(GUARD - 1);
                            state_r   <= ST_GUARD;
                            ready_r   <= 1'b0;
                            busy_r    <= 1'b1;
                        end
                    end
                end
                ST_GUARD: begin
                    if (cnt_r == '0) begin
                        state_r <= ST_SWITCH;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_SWITCH: begin
                    for (int i = 0; i < COUNT; i++) begin
                        if (pin_r == 4'(i)) begin
                            sel_r[2*i +: 2] <= sel_lat_r;
                        end
                    end
                    cnt_r   <= CW'(SETTLE - 1);
                    state_r <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_r == '0) begin
                        oeb_r   <= '0;
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a released, idle pad.
                    oeb_r   <= '0;
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign sel       = sel_r;
    assign oeb_force = oeb_r;
    assign req_ready = ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_pin_mux_sel_ctrl.sv
// Directed self-checking bench for pin_mux_sel_ctrl: default, COUNT=12 and
// GUARD=SETTLE=1 instances share clock and reset.
module tb_pin_mux_sel_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    // Default instance
    logic        req_valid, req_ready, busy, done, err;
    logic [3:0]  req_pin;
    logic [1:0]  req_sel;
    logic [15:0] lock, oeb_force;
    logic [31:0] sel;

    pin_mux_sel_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_pin(req_pin), .req_sel(req_sel), .lock(lock), .sel(sel),
        .oeb_force(oeb_force), .busy(busy), .done(done), .err(err)
    );

    // COUNT=12 instance
    logic        v2, r2, b2, d2, e2;
    logic [3:0]  p2;
    logic [1:0]  s2;
    logic [11:0] l2, o2;
    logic [23:0] sel2;

    pin_mux_sel_ctrl #(.COUNT(12)) dut2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_ready(r2),
        .req_pin(p2), .req_sel(s2), .lock(l2), .sel(sel2),
        .oeb_force(o2), .busy(b2), .done(d2), .err(e2)
    );

    // GUARD=1, SETTLE=1 instance
    logic        v3, r3, b3, d3, e3;
    logic [3:0]  p3;
    logic [1:0]  s3;
    logic [15:0] l3, o3;
    logic [31:0] sel3;

    pin_mux_sel_ctrl #(.GUARD(1), .SETTLE(1)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_ready(r3),
        .req_pin(p3), .req_sel(s3), .lock(l3), .sel(sel3),
        .oeb_force(o3), .busy(b3), .done(d3), .err(e3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_checks++;
        if ({sel, oeb_force, busy, done, err, req_ready} !== {32'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset: sel=%h oeb=%h busy=%b done=%b err=%b ready=%b, want 0/0/0/0/0/1",
                     sel, oeb_force, busy, done, err, req_ready);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if ({sel2, o2, sel3, o3, r2, r3} !== {24'h0, 12'h0, 32'h0, 16'h0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_others: sel2=%h o2=%h sel3=%h o3=%h", sel2, o2, sel3, o3);
        end
    endtask

    // Generic single-change sequence on the default instance (GUARD=4, SETTLE=2).
    task automatic run_change(input string name, input logic [3:0] pin,
                              input logic [1:0] nsel, input logic [31:0] sel_before);
        logic [31:0] sel_after;
        logic [15:0] mask;
        sel_after = sel_before;
        sel_after[2*pin +: 2] = nsel;
        mask = 16'h0001 << pin;
        req_pin = pin; req_sel = nsel; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            n_checks++;
            if (oeb_force !== ((k <= 7) ? mask : 16'h0)) begin
                n_fail++;
                $display("FAIL %s oeb k=%0d: got %h want %h", name, k, oeb_force, (k <= 7) ? mask : 16'h0);
            end
            n_checks++;
            if (sel !== ((k >= 6) ? sel_after : sel_before)) begin
                n_fail++;
                $display("FAIL %s sel k=%0d: got %h want %h", name, k, sel, (k >= 6) ? sel_after : sel_before);
            end
            n_checks++;
            if ({done, busy, req_ready, err} !== {(k == 8), (k <= 7), (k == 8), 1'b0}) begin
                n_fail++;
                $display("FAIL %s ctl k=%0d: done/busy/ready/err got %b%b%b%b",
                         name, k, done, busy, req_ready, err);
            end
            tick();
        end
    endtask

    task automatic test_change();
        run_change("change_p3", 4'd3, 2'd2, 32'h0);
    endtask

    task automatic test_noop();
        req_pin = 4'd5; req_sel = 2'd0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({done, err, busy, req_ready, oeb_force, sel} !== {1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 32'h80}) begin
            n_fail++;
            $display("FAIL noop: done=%b err=%b busy=%b ready=%b oeb=%h sel=%h",
                     done, err, busy, req_ready, oeb_force, sel);
        end
        tick();
        n_checks++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL noop_pulse: done=%b busy=%b want 00", done, busy);
        end
    endtask

    task automatic test_reject();
        lock = 16'h0004;
        req_pin = 4'd2; req_sel = 2'd1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({err, done, busy, req_ready, oeb_force, sel} !== {1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 32'h80}) begin
            n_fail++;
            $display("FAIL reject_lock: err=%b done=%b busy=%b ready=%b oeb=%h sel=%h",
                     err, done, busy, req_ready, oeb_force, sel);
        end
        tick();
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL reject_pulse: err=%b want 0", err);
        end
        lock = 16'h0;
        p2 = 4'd13; s2 = 2'd1; v2 = 1'b1;
        tick();
        v2 = 1'b0;
        n_checks++;
        if ({e2, d2, b2, r2, o2, sel2} !== {1'b1, 1'b0, 1'b0, 1'b1, 12'h0, 24'h0}) begin
            n_fail++;
            $display("FAIL reject_range: err=%b done=%b busy=%b ready=%b oeb=%h sel=%h",
                     e2, d2, b2, r2, o2, sel2);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_oeb;
        req_pin = 4'd0; req_sel = 2'd1; req_valid = 1'b1;
        tick();
        req_pin = 4'd15; req_sel = 2'd3;
        for (int k = 1; k <= 16; k++) begin
            if (k == 9) req_valid = 1'b0;
            exp_oeb = (k <= 7) ? 16'h0001 : ((k >= 9 && k <= 15) ? 16'h8000 : 16'h0000);
            n_checks++;
            if (oeb_force !== exp_oeb) begin
                n_fail++;
                $display("FAIL b2b oeb k=%0d: got %h want %h", k, oeb_force, exp_oeb);
            end
            n_checks++;
            if ({done, req_ready} !== {(k == 8 || k == 16), (k == 8 || k == 16)}) begin
                n_fail++;
                $display("FAIL b2b ctl k=%0d: done=%b ready=%b", k, done, req_ready);
            end
            tick();
        end
        n_checks++;
        if (sel !== 32'hC000_0081) begin
            n_fail++;
            $display("FAIL b2b sel: got %h want c0000081", sel);
        end
    endtask

    task automatic test_reset_mid();
        req_pin = 4'd4; req_sel = 2'd3; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({oeb_force, sel, busy, req_ready, done, err} !== {16'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: oeb=%h sel=%h busy=%b ready=%b done=%b err=%b",
                     oeb_force, sel, busy, req_ready, done, err);
        end
        #2;
        rst = 1'b0;
        tick();
        run_change("after_rst_p4", 4'd4, 2'd3, 32'h0);
    endtask

    task automatic test_fast();
        p3 = 4'd1; s3 = 2'd2; v3 = 1'b1;
        tick();
        v3 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (o3 !== ((k <= 3) ? 16'h0002 : 16'h0)) begin
                n_fail++;
                $display("FAIL fast oeb k=%0d: got %h", k, o3);
            end
            n_checks++;
            if (sel3 !== ((k >= 3) ? 32'h8 : 32'h0)) begin
                n_fail++;
                $display("FAIL fast sel k=%0d: got %h", k, sel3);
            end
            n_checks++;
            if (d3 !== (k == 4)) begin
                n_fail++;
                $display("FAIL fast done k=%0d: got %b", k, d3);
            end
            tick();
        end
    endtask

    initial begin
        req_valid = 1'b0; req_pin = 4'd0; req_sel = 2'd0; lock = 16'h0;
        v2 = 1'b0; p2 = 4'd0; s2 = 2'd0; l2 = 12'h0;
        v3 = 1'b0; p3 = 4'd0; s3 = 2'd0; l3 = 16'h0;
        test_reset();
        test_change();
        test_noop();
        test_reject();
        test_back_to_back();
        test_reset_mid();
        test_fast();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
